instr_fetch_unit: RTL and testbench

Fetch stage of the 54-instruction MIPS core. It holds the PC, issues word reads to instruction memory with a request/ready handshake, and captures the returned word in an instruction register. It presents `raw_instruction` plus a valid strobe that drives the decoder's `ena` input directly. It stalls on backend busy and accepts redirects (branch, jump, exception, eret) with a defined flush of in-flight fetches.

---
 rtl/cpu54_pkg.sv | 17 +
 rtl/instr_fetch_unit.sv | 136 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cpu54_pkg.sv
// Shared definitions for the cpu54 core: fetch FSM encoding, reset vector, NOP word.
package cpu54_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0000;

  function automatic logic is_misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem request/ready handshake, instruction register with valid strobe.
// One instruction per 2 cycles at zero wait; holds on stall; redirects flush in-flight fetches.
module instr_fetch_unit
  import cpu54_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       raw_instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_fault
);

  fetch_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_pend_pc, w_pend_nxt;
  logic [ADDR_W-1:0] r_pc_out, w_pc_out_nxt;
  logic [31:0]       r_instr, w_instr_nxt;
  logic              r_drop, w_drop_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_fault, w_fault_nxt;
  logic [ADDR_W-1:0] w_target;

  // A same-cycle redirect beats any target parked while the request was outstanding.
  assign w_target = redirect_valid ? redirect_pc : r_pend_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_REQ;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_pend_nxt   = r_pend_pc;
    w_pc_out_nxt = r_pc_out;
    w_instr_nxt  = r_instr;
    w_drop_nxt   = r_drop;
    w_valid_nxt  = r_valid;
    w_fault_nxt  = r_fault;
    case (r_state)
      S_REQ: begin
        if (imem_ready) begin
          if (r_drop || redirect_valid) begin
            w_drop_nxt = 1'b0;
            if (is_misaligned(w_target[1:0])) begin
              w_state_nxt  = S_FAULT;
              w_fault_nxt  = 1'b1;
              w_pc_out_nxt = w_target;
            end else begin
              w_pc_nxt = w_target;
            end
          end else begin
            w_instr_nxt  = imem_rdata;
            w_pc_out_nxt = r_pc;
            w_pc_nxt     = r_pc + ADDR_W'(4);
            w_valid_nxt  = 1'b1;
            w_state_nxt  = S_VALID;
          end
        end else if (redirect_valid) begin
          // Address must stay put until ready; remember where to go afterwards.
          w_pend_nxt = redirect_pc;
          w_drop_nxt = 1'b1;
        end
      end
      S_VALID: begin
        if (redirect_valid) begin
          w_valid_nxt = 1'b0;
          if (is_misaligned(redirect_pc[1:0])) begin
            w_state_nxt  = S_FAULT;
            w_fault_nxt  = 1'b1;
            w_pc_out_nxt = redirect_pc;
          end else begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = S_REQ;
          end
        end else if (!stall) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_REQ;
        end
      end
      S_FAULT: begin
        if (redirect_valid) begin
          if (is_misaligned(redirect_pc[1:0])) begin
            w_pc_out_nxt = redirect_pc;
          end else begin
            w_fault_nxt = 1'b0;
            w_pc_nxt    = redirect_pc;
            w_state_nxt = S_REQ;
          end
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_pend_pc <= '0;
      r_pc_out  <= RESET_PC;
      r_instr   <= INSTR_NOP;
      r_drop    <= 1'b0;
      r_valid   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_pend_pc <= w_pend_nxt;
      r_pc_out  <= w_pc_out_nxt;
      r_instr   <= w_instr_nxt;
      r_drop    <= w_drop_nxt;
      r_valid   <= w_valid_nxt;
      r_fault   <= w_fault_nxt;
    end
  end

  assign imem_req        = (r_state == S_REQ);
  assign imem_addr       = r_pc;
  assign raw_instruction = r_instr;
  assign instr_valid     = r_valid;
  assign pc_out          = r_pc_out;
  assign pc_plus4        = r_pc_out + ADDR_W'(4);
  assign fetch_fault     = r_fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs change and outputs are sampled on the falling edge.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] raw_instruction;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        fetch_fault;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .raw_instruction(raw_instruction),
    .instr_valid    (instr_valid),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; imem_rdata = '0; imem_ready = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_raw",   raw_instruction, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_pcout", pc_out, 32'h0040_0000);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_addr",  imem_addr, 32'h0040_0000);

    // First fetch, zero-wait memory
    rst_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
    chk("f1_req",  {31'b0, imem_req}, 32'd1);
    chk("f1_addr", imem_addr, 32'h0040_0000);
    tick();
    imem_ready = 1'b0;
    chk("f1_raw",   raw_instruction, 32'h2008_0005);
    chk("f1_valid", {31'b0, instr_valid}, 32'd1);
    chk("f1_pcout", pc_out, 32'h0040_0000);
    chk("f1_pcp4",  pc_plus4, 32'h0040_0004);
    chk("f1_req0",  {31'b0, imem_req}, 32'd0);

    // Stall holds the instruction for 3 cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_raw",   raw_instruction, 32'h2008_0005);
      chk("st_pcout", pc_out, 32'h0040_0000);
      chk("st_valid", {31'b0, instr_valid}, 32'd1);
      chk("st_req",   {31'b0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("st_next_addr", imem_addr, 32'h0040_0004);
    chk("st_next_req",  {31'b0, imem_req}, 32'd1);
    chk("st_consumed",  {31'b0, instr_valid}, 32'd0);

    // Wait states with a redirect parked mid-request
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
    tick();
    redirect_valid = 1'b0; redirect_pc = '0;
    chk("ws_addr_a", imem_addr, 32'h0040_0004);
    tick();
    chk("ws_addr_b", imem_addr, 32'h0040_0004);
    chk("ws_req",    {31'b0, imem_req}, 32'd1);
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("ws_dropped", {31'b0, instr_valid}, 32'd0);
    chk("ws_raw_kept", raw_instruction, 32'h2008_0005);
    chk("ws_new_addr", imem_addr, 32'h0040_0100);
    chk("ws_new_req",  {31'b0, imem_req}, 32'd1);

    // Fetch at the redirect target, then redirect+stall together
    imem_rdata = 32'h1111_1111;
    tick();
    imem_ready = 1'b0;
    chk("rd_raw",   raw_instruction, 32'h1111_1111);
    chk("rd_pcout", pc_out, 32'h0040_0100);
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0020; stall = 1'b1;
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    chk("rs_valid", {31'b0, instr_valid}, 32'd0);
    chk("rs_addr",  imem_addr, 32'h0040_0020);

    // Misaligned redirect -> fault, then recovery
    imem_ready = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    imem_ready = 1'b0;
    chk("fl_pre_pcout", pc_out, 32'h0040_0020);
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0022;
    tick();
    redirect_valid = 1'b0;
    chk("fl_fault", {31'b0, fetch_fault}, 32'd1);
    chk("fl_req",   {31'b0, imem_req}, 32'd0);
    chk("fl_valid", {31'b0, instr_valid}, 32'd0);
    chk("fl_pcout", pc_out, 32'h0040_0022);
    tick();
    chk("fl_hold",  {31'b0, fetch_fault}, 32'd1);
    chk("fl_hreq",  {31'b0, imem_req}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0031;
    tick();
    chk("fl_mis2_pcout", pc_out, 32'h0040_0031);
    chk("fl_mis2_fault", {31'b0, fetch_fault}, 32'd1);
    redirect_pc = 32'h0040_0180;
    tick();
    redirect_valid = 1'b0;
    chk("fl_clear", {31'b0, fetch_fault}, 32'd0);
    chk("fl_req1",  {31'b0, imem_req}, 32'd1);
    chk("fl_addr",  imem_addr, 32'h0040_0180);

    // Redirect coinciding with ready: word discarded, go to top of memory
    imem_ready = 1'b1; imem_rdata = 32'h4444_4444;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wr_nodata", {31'b0, instr_valid}, 32'd0);
    chk("wr_addr",   imem_addr, 32'hFFFF_FFFC);
    imem_rdata = 32'h3333_3333;
    tick();
    imem_ready = 1'b0;
    chk("wr_raw",   raw_instruction, 32'h3333_3333);
    chk("wr_pcout", pc_out, 32'hFFFF_FFFC);
    chk("wr_pcp4",  pc_plus4, 32'h0000_0000);
    tick();
    chk("wr_next_addr", imem_addr, 32'h0000_0000);
    chk("wr_next_req",  {31'b0, imem_req}, 32'd1);

    // Asynchronous reset in the middle of a wait state
    tick();
    rst_n = 1'b0;
    #1;
    chk("ar_raw",   raw_instruction, 32'h0);
    chk("ar_valid", {31'b0, instr_valid}, 32'd0);
    chk("ar_pcout", pc_out, 32'h0040_0000);
    chk("ar_addr",  imem_addr, 32'h0040_0000);
    chk("ar_fault", {31'b0, fetch_fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("ar_post_addr", imem_addr, 32'h0040_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
